// File: rtl/data_mem_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_bridge_if : word-oriented memory bus between bridge & RAM  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface data_mem_bridge_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_bridge : core load/store to word memory, split unaligned   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module data_mem_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        req_valid_i,
   input  wire logic        RAM_rw_i,
   input  wire logic [31:0] RAM_Addr_i,
   input  wire logic [31:0] RAM_DATA_i,
   input  wire logic [2:0]  RAM_DATA_control_i,
   output logic             stall_o,
   output logic [31:0]      load_data_o,
   output logic             done_o,
   output logic             err_o,
   data_mem_bridge_if.master mem
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BEAT0 = 2'd1;
   localparam logic [1:0] S_BEAT1 = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

   logic [1:0]           state_q, state_d;
   logic                 rw_q;
   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
   logic [2:0]           f3_q;
   logic [TIMEOUT_W-1:0] tcnt_q;
   logic [31:0]          rbuf_q;
   logic                 err_q;
   logic [31:0]          load_q;

   logic        w_req_invalid;
   logic        w_in_beat;
   logic [1:0]  w_off;
   logic [4:0]  w_sh;
   logic [5:0]  w_sh_hi;
   logic [3:0]  w_mask;
   logic [7:0]  w_be_full;
   logic        w_split;
   logic        w_timeout;
   logic        w_last_ack;
   logic [31:0] w_rd0;
   logic [31:0] w_rd1;
   logic [31:0] w_assembled;
   logic [31:0] w_load_ext;
   logic [31:0] w_base;

   assign w_req_invalid = (RAM_DATA_control_i == 3'b011) ||
                          (RAM_DATA_control_i[2:1] == 2'b11) ||
                          (RAM_DATA_control_i[2] && RAM_rw_i);

   assign w_in_beat = (state_q == S_BEAT0) || (state_q == S_BEAT1);
   assign w_off     = addr_q[1:0];
   assign w_sh      = {w_off, 3'b000};
   assign w_sh_hi   = 6'd32 - {1'b0, w_sh};
   assign w_base    = {addr_q[31:2], 2'b00};

   always_comb begin
      case (f3_q[1:0])
         2'b00:   w_mask = 4'b0001;
         2'b01:   w_mask = 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   // Upper nibble of the shifted mask is the lane set spilling into the next word.
   assign w_be_full  = {4'b0000, w_mask} << w_off;
   assign w_split    = |w_be_full[7:4];
   assign w_timeout  = w_in_beat && !mem.mem_ack_i && (tcnt_q == TMO_LAST);
   assign w_last_ack = w_in_beat && mem.mem_ack_i && ((state_q == S_BEAT1) || !w_split);

   assign w_rd0       = mem.mem_rdata_i >> w_sh;
   assign w_rd1       = mem.mem_rdata_i << w_sh_hi;
   assign w_assembled = (state_q == S_BEAT1) ? (rbuf_q | w_rd1) : w_rd0;

   always_comb begin
      case (f3_q)
         3'b000:  w_load_ext = {{24{w_assembled[7]}}, w_assembled[7:0]};
         3'b001:  w_load_ext = {{16{w_assembled[15]}}, w_assembled[15:0]};
         3'b010:  w_load_ext = w_assembled;
         3'b100:  w_load_ext = {24'd0, w_assembled[7:0]};
         3'b101:  w_load_ext = {16'd0, w_assembled[15:0]};
         default: w_load_ext = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               state_d = w_req_invalid ? S_DONE : S_BEAT0;
            end
         end
         S_BEAT0: begin
            if (mem.mem_ack_i) begin
               state_d = w_split ? S_BEAT1 : S_DONE;
            end else if (w_timeout) begin
               state_d = S_DONE;
            end
         end
         S_BEAT1: begin
            if (mem.mem_ack_i || w_timeout) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_o         = ((state_q == S_IDLE) && req_valid_i) || w_in_beat;
      done_o          = (state_q == S_DONE);
      err_o           = (state_q == S_DONE) && err_q;
      load_data_o     = load_q;
      mem.mem_req_o   = w_in_beat;
      mem.mem_we_o    = 1'b0;
      mem.mem_addr_o  = 32'd0;
      mem.mem_be_o    = 4'b0000;
      mem.mem_wdata_o = 32'd0;
      if (state_q == S_BEAT0) begin
         mem.mem_we_o    = rw_q;
         mem.mem_addr_o  = w_base;
         mem.mem_be_o    = w_be_full[3:0];
         mem.mem_wdata_o = wdata_q << w_sh;
      end else if (state_q == S_BEAT1) begin
         mem.mem_we_o    = rw_q;
         mem.mem_addr_o  = w_base + 32'd4;
         mem.mem_be_o    = w_be_full[7:4];
         mem.mem_wdata_o = wdata_q >> w_sh_hi;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rw_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         tcnt_q  <= '0;
         rbuf_q  <= 32'd0;
         err_q   <= 1'b0;
         load_q  <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  rw_q    <= RAM_rw_i;
                  addr_q  <= RAM_Addr_i;
                  wdata_q <= RAM_DATA_i;
                  f3_q    <= RAM_DATA_control_i;
                  tcnt_q  <= '0;
                  err_q   <= w_req_invalid;
                  if (w_req_invalid) begin
                     load_q <= 32'd0;
                  end
               end
            end
            S_BEAT0, S_BEAT1: begin
               if (mem.mem_ack_i) begin
                  tcnt_q <= '0;
                  if (state_q == S_BEAT0) begin
                     rbuf_q <= w_rd0;
                  end
                  if (w_last_ack) begin
                     load_q <= rw_q ? 32'd0 : w_load_ext;
                  end
               end else if (w_timeout) begin
                  err_q  <= 1'b1;
                  load_q <= 32'd0;
                  tcnt_q <= '0;
               end else begin
                  tcnt_q <= tcnt_q + TMO_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
